mandel_iter_engine: RTL and testbench
=====================================

MANDEL_ITER_ENGINE -- requirements
Module: mandel_iter_engine

Interface
REQ-001 SHALL have parameter X_SIZE, default 640: pixels per line.
REQ-002 SHALL have parameter Y_SIZE, default 480: lines per frame.
REQ-003 SHALL have parameter DATA_W, default 18: signed fixed-point width of c and z.
REQ-004 SHALL have parameter FRAC_BITS, default 12: fraction bits; DATA_W-FRAC_BITS >= 4 is enforced by elaboration assertion.
REQ-005 SHALL have parameter ITER_W, default 8: iteration counter width.
REQ-006 SHALL have port aclk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port areset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port cfg_x0 / cfg_y0, input, DATA_W signed each: real/imag c of pixel (0,0).
REQ-009 SHALL have port cfg_dx / cfg_dy, input, DATA_W signed each: c step per x / per y.
REQ-010 SHALL have port cfg_max_iter, input, ITER_W: iteration limit; 0 is treated as 1.
REQ-011 SHALL have port enable, input, 1: allows a new frame to start.
REQ-012 SHALL have port pix_rgb, output, 24: colour {r,g,b}.
REQ-013 SHALL have port pix_iter, output, ITER_W: final iteration count n.
REQ-014 SHALL have port pix_escaped, output, 1: pixel escaped before the limit.
REQ-015 SHALL have port pix_sof / pix_eol, output, 1 each: first pixel of frame / last pixel of line.
REQ-016 SHALL have port pix_valid (output, 1) and pix_ready (input, 1): stream handshake.
REQ-017 SHALL have port frame_done, output, 1: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-018 SHALL implement states IDLE, INIT, ITER, OUT.
REQ-019 IDLE SHALL go to INIT when enable=1; on entry to INIT at pixel (0,0), all cfg_* SHALL be latched and held for the whole frame.
REQ-020 INIT SHALL compute cr=x0+x*dx and ci=y0+y*dy incrementally (accumulate dx per pixel, dy per line), set zr=zi=0 and n=0, then go to ITER (1 cycle).
REQ-021 Each ITER cycle SHALL form zr², zi² and zr*zi at full 2*DATA_W width from the current z; all updates SHALL use old z values simultaneously.
REQ-022 Escape SHALL be declared when zr²+zi² > 4<<(2*FRAC_BITS), compared strictly at 2*DATA_W+1 bits.
REQ-023 On escape, or when n == limit, ITER SHALL go to OUT; otherwise zr' = ((zr²-zi²)>>>FRAC_BITS)+cr and zi' = ((2*zr*zi)>>>FRAC_BITS)+ci, both truncated to DATA_W, and n increments.
REQ-024 A pixel SHALL therefore occupy 1 INIT cycle plus n+1 ITER cycles before pix_valid rises.
REQ-025 In OUT, pix_valid SHALL be 1 and all pix_* SHALL be held stable until pix_ready=1; acceptance occurs on the cycle where valid&ready are both 1.
REQ-026 Colour SHALL be r=(n*n) mod 256, g=(n*n*n) mod 256, b=n mod 256 when escaped, and pix_rgb=0 when not escaped.
REQ-027 On acceptance, x SHALL increment; at x=X_SIZE-1, x SHALL wrap to 0 and y increment; at (X_SIZE-1, Y_SIZE-1) both SHALL wrap to 0, frame_done SHALL pulse the next cycle, and the state SHALL go to IDLE (or INIT the next cycle if enable=1).
REQ-028 Otherwise, on acceptance, OUT SHALL go to INIT.
REQ-029 pix_sof SHALL be 1 only for (0,0); pix_eol SHALL be 1 only for x=X_SIZE-1.
REQ-030 Deasserting enable mid-frame SHALL NOT stop the frame; it SHALL be sampled only at frame boundaries.
REQ-031 pix_valid SHALL be 0 in IDLE, INIT and ITER.

Reset
REQ-032 When areset=1 at a clock edge, the block SHALL enter IDLE with x=y=0 and n=0.
REQ-033 During reset, pix_valid, frame_done, pix_sof, pix_eol and pix_escaped SHALL be 0, and pix_rgb and pix_iter SHALL be 0.
REQ-034 Reset mid-ITER or mid-OUT SHALL discard the pixel; the next frame SHALL restart at (0,0).

Structure
REQ-035 Package mandel_pkg SHALL hold the state enum, the escape-threshold function of FRAC_BITS, and the colour-map function.
REQ-036 The per-cycle z update and escape compare SHALL be a combinational sub-module mandel_step, instantiated once.

Verification
REQ-037 Never-escapes case: DATA_W=18, FRAC_BITS=12, c=0, max_iter=15 -> pix_iter=15, pix_escaped=0, pix_rgb=0, valid 17 cycles after INIT entry.
REQ-038 Escape case: c=2.0 (cr=8192, ci=0), max_iter=15 -> |z|²=4 is not >4, so pix_iter=2, pix_escaped=1, pix_rgb=0x040802.
REQ-039 Backpressure: hold pix_ready=0 for 10 cycles in OUT -> pix_valid stays 1 and pix_* stay constant; exactly one acceptance follows.
REQ-040 Small frame: X_SIZE=4, Y_SIZE=2, ready=1 -> 8 pixels; sof on pixel 0; eol on pixels 3 and 7; frame_done pulses once, one cycle after pixel 7.
REQ-041 Config stability: change cfg_x0 mid-frame -> the current frame's colours are unchanged; the new value takes effect only from the next frame.
REQ-042 Reset: assert areset during ITER of pixel (2,0) -> pix_valid=0 the next cycle; after release with enable=1, the first output has sof=1 at (0,0).

Source files
------------

// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared state type, escape threshold and colour map for the Mandelbrot engine
package mandel_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_ITER = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // |z|^2 escape bound: 4.0 expressed with 2*frac_bits fraction bits
    function automatic logic [63:0] esc_threshold(input int frac_bits);
        return 64'd4 << (2 * frac_bits);
    endfunction

    function automatic logic [23:0] color_map(input logic [7:0] n, input logic escaped);
        logic [7:0] r;
        logic [7:0] g;
        r = n * n;
        g = r * n;
        return escaped ? {r, g, n} : 24'd0;
    endfunction

endpackage

// File: rtl/mandel_step.sv
// rtl/mandel_step.sv - one combinational z <- z^2 + c step with escape compare
module mandel_step
    import mandel_pkg::*;
#(
    parameter int DATA_W    = 18,
    parameter int FRAC_BITS = 12
) (
    input  logic signed [DATA_W-1:0] zr,
    input  logic signed [DATA_W-1:0] zi,
    input  logic signed [DATA_W-1:0] cr,
    input  logic signed [DATA_W-1:0] ci,
    output logic signed [DATA_W-1:0] zr_next,
    output logic signed [DATA_W-1:0] zi_next,
    output logic                     escape
);

    localparam int MW = 2 * DATA_W + 1;
    localparam logic signed [MW-1:0] THRESH = MW'(esc_threshold(FRAC_BITS));

    logic signed [MW-1:0] zr_w;
    logic signed [MW-1:0] zi_w;
    logic signed [MW-1:0] zr_sq;
    logic signed [MW-1:0] zi_sq;
    logic signed [MW-1:0] zr_zi;

    // One guard bit above the full product width keeps 2*zr*zi and the sum exact
    always_comb begin
        zr_w    = MW'(zr);
        zi_w    = MW'(zi);
        zr_sq   = zr_w * zr_w;
        zi_sq   = zi_w * zi_w;
        zr_zi   = zr_w * zi_w;
        escape  = (zr_sq + zi_sq) > THRESH;
        zr_next = DATA_W'((zr_sq - zi_sq) >>> FRAC_BITS) + cr;
        zi_next = DATA_W'((zr_zi <<< 1) >>> FRAC_BITS) + ci;
    end

endmodule

// File: rtl/mandel_iter_engine.sv
// rtl/mandel_iter_engine.sv - frame-scanning Mandelbrot iteration engine with pixel stream output
module mandel_iter_engine
    import mandel_pkg::*;
#(
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int DATA_W    = 18,
    parameter int FRAC_BITS = 12,
    parameter int ITER_W    = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic signed [DATA_W-1:0] cfg_x0,
    input  logic signed [DATA_W-1:0] cfg_y0,
    input  logic signed [DATA_W-1:0] cfg_dx,
    input  logic signed [DATA_W-1:0] cfg_dy,
    input  logic [ITER_W-1:0]        cfg_max_iter,
    input  logic                     enable,
    output logic [23:0]              pix_rgb,
    output logic [ITER_W-1:0]        pix_iter,
    output logic                     pix_escaped,
    output logic                     pix_sof,
    output logic                     pix_eol,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     frame_done
);

    if (DATA_W - FRAC_BITS < 4) begin : g_bad_format
        $error("mandel_iter_engine: DATA_W-FRAC_BITS must be at least 4");
    end

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    state_t state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic signed [DATA_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic signed [DATA_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [DATA_W-1:0] cr_q, cr_d, ci_q, ci_d;
    logic signed [DATA_W-1:0] zr_q, zr_d, zi_q, zi_d;
    logic [ITER_W-1:0] lim_q, lim_d, n_q, n_d;
    logic esc_q, esc_d;
    logic frame_done_q, frame_done_d;

    logic signed [DATA_W-1:0] zr_nx, zi_nx;
    logic step_esc;
    logic last_x, last_y;

    mandel_step #(
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_step (
        .zr     (zr_q),
        .zi     (zi_q),
        .cr     (cr_q),
        .ci     (ci_q),
        .zr_next(zr_nx),
        .zi_next(zi_nx),
        .escape (step_esc)
    );

    assign last_x = (x_q == XW'(X_SIZE - 1));
    assign last_y = (y_q == YW'(Y_SIZE - 1));

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        cr_d         = cr_q;
        ci_d         = ci_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        lim_d        = lim_q;
        n_d          = n_q;
        esc_d        = esc_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Frame configuration is captured once here and held until the frame ends
                if (enable) begin
                    state_d = S_INIT;
                    x0_d    = cfg_x0;
                    y0_d    = cfg_y0;
                    dx_d    = cfg_dx;
                    dy_d    = cfg_dy;
                    lim_d   = (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
                    cr_d    = cfg_x0;
                    ci_d    = cfg_y0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_INIT: begin
                zr_d    = '0;
                zi_d    = '0;
                n_d     = '0;
                esc_d   = 1'b0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (step_esc) begin
                    esc_d   = 1'b1;
                    state_d = S_OUT;
                end else if (n_q == lim_q) begin
                    state_d = S_OUT;
                end else begin
                    zr_d = zr_nx;
                    zi_d = zi_nx;
                    n_d  = n_q + ITER_W'(1);
                end
            end
            S_OUT: begin
                // c for the next pixel is stepped here so INIT only has to clear z
                if (pix_ready) begin
                    state_d = S_INIT;
                    if (last_x) begin
                        x_d  = '0;
                        cr_d = x0_q;
                        if (last_y) begin
                            y_d          = '0;
                            ci_d         = y0_q;
                            frame_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else begin
                            y_d  = y_q + YW'(1);
                            ci_d = ci_q + dy_q;
                        end
                    end else begin
                        x_d  = x_q + XW'(1);
                        cr_d = cr_q + dx_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            cr_q         <= '0;
            ci_q         <= '0;
            zr_q         <= '0;
            zi_q         <= '0;
            lim_q        <= '0;
            n_q          <= '0;
            esc_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            cr_q         <= cr_d;
            ci_q         <= ci_d;
            zr_q         <= zr_d;
            zi_q         <= zi_d;
            lim_q        <= lim_d;
            n_q          <= n_d;
            esc_q        <= esc_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_valid   = (state_q == S_OUT);
    assign pix_iter    = n_q;
    assign pix_escaped = esc_q;
    assign pix_rgb     = color_map(8'(n_q), esc_q);
    assign pix_sof     = pix_valid && (x_q == '0) && (y_q == '0);
    assign pix_eol     = pix_valid && last_x;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_mandel_iter_engine.sv
// tb/tb_mandel_iter_engine.sv - self-checking bench for mandel_iter_engine on a 4x2 frame
module tb_mandel_iter_engine;

    localparam int DW = 18;
    localparam int FB = 12;
    localparam int IW = 8;
    localparam int XS = 4;
    localparam int YS = 2;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic signed [DW-1:0] cfg_x0, cfg_y0, cfg_dx, cfg_dy;
    logic [IW-1:0]        cfg_max_iter;
    logic                 enable;
    logic [23:0]          pix_rgb;
    logic [IW-1:0]        pix_iter;
    logic                 pix_escaped, pix_sof, pix_eol, pix_valid;
    logic                 pix_ready;
    logic                 frame_done;

    mandel_iter_engine #(
        .X_SIZE(XS), .Y_SIZE(YS), .DATA_W(DW), .FRAC_BITS(FB), .ITER_W(IW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
        .cfg_max_iter(cfg_max_iter), .enable(enable),
        .pix_rgb(pix_rgb), .pix_iter(pix_iter), .pix_escaped(pix_escaped),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    int first_iter, first_lat;
    logic first_esc;
    logic [23:0] first_rgb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint trunc(input longint v);
        return (v <<< (64 - DW)) >>> (64 - DW);
    endfunction

    // Reference: iterate z = z^2 + c directly in wide integer arithmetic
    function automatic void model_pixel(input longint cr, input longint ci, input int maxit,
                                        output int n, output bit esc);
        longint zr, zi, zr2, zi2, nr, ni;
        int lim;
        lim = (maxit == 0) ? 1 : maxit;
        zr = 0; zi = 0; n = 0; esc = 0;
        for (int k = 0; k < 300; k++) begin
            zr2 = zr * zr;
            zi2 = zi * zi;
            if (zr2 + zi2 > (longint'(4) << (2 * FB))) begin
                esc = 1;
                break;
            end
            if (n == lim) break;
            nr = trunc(((zr2 - zi2) >>> FB) + cr);
            ni = trunc(((2 * zr * zi) >>> FB) + ci);
            zr = nr;
            zi = ni;
            n++;
        end
    endfunction

    function automatic logic [23:0] model_rgb(input int n, input bit esc);
        logic [7:0] r, g, b;
        r = 8'((n * n) % 256);
        g = 8'((n * n * n) % 256);
        b = 8'(n % 256);
        return esc ? {r, g, b} : 24'd0;
    endfunction

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (pix_valid !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        if (pix_valid !== 1'b1) chk("valid_timeout", {63'd0, pix_valid}, 64'd1);
    endtask

    // mode 0: ready at once; 1: random 0..3 cycle stall; 2: 10-cycle stall on pixel 1
    task automatic run_frame(input int mode, input bit chg_cfg);
        longint fx0, fy0, fdx, fdy;
        int fmax, cyc, n, d;
        bit esc;
        logic [35:0] exp_bus;
        fx0 = longint'(cfg_x0); fy0 = longint'(cfg_y0);
        fdx = longint'(cfg_dx); fdy = longint'(cfg_dy);
        fmax = int'(cfg_max_iter);
        enable = 1'b1;
        for (int p = 0; p < XS * YS; p++) begin
            int x, y;
            x = p % XS;
            y = p / XS;
            wait_valid(cyc);
            enable = 1'b0;
            model_pixel(trunc(fx0 + x * fdx), trunc(fy0 + y * fdy), fmax, n, esc);
            chk("latency", 64'(cyc), 64'((p == 0) ? n + 3 : n + 2));
            if (chg_cfg && p == 2) cfg_x0 = DW'($urandom);
            exp_bus = {1'b1, model_rgb(n, esc), IW'(n), esc, (p == 0), (x == XS - 1)};
            d = (mode == 2 && p == 1) ? 10 : (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            for (int k = 0; k < d; k++) begin
                chk("hold_stable", {28'd0, pix_valid, pix_rgb, pix_iter, pix_escaped, pix_sof, pix_eol},
                    {28'd0, exp_bus});
                tick();
            end
            chk("pix_iter", 64'(pix_iter), 64'(n));
            chk("pix_escaped", {63'd0, pix_escaped}, {63'd0, esc});
            chk("pix_rgb", 64'(pix_rgb), 64'(model_rgb(n, esc)));
            chk("pix_sof", {63'd0, pix_sof}, 64'(p == 0));
            chk("pix_eol", {63'd0, pix_eol}, 64'(x == XS - 1));
            if (p == 0) begin
                first_iter = n;
                first_lat  = cyc;
                first_iter = int'(pix_iter);
                first_esc  = pix_escaped;
                first_rgb  = pix_rgb;
            end
            pix_ready = 1'b1;
            tick();
            pix_ready = 1'b0;
            chk("valid_drop", {63'd0, pix_valid}, 64'd0);
            chk("frame_done", {63'd0, frame_done}, 64'(p == XS * YS - 1));
        end
        tick();
        chk("frame_done_once", {63'd0, frame_done}, 64'd0);
        chk("idle_after_frame", {63'd0, pix_valid}, 64'd0);
    endtask

    task automatic set_cfg(input int x0, input int y0, input int dx, input int dy, input int mi);
        cfg_x0 = DW'(x0);
        cfg_y0 = DW'(y0);
        cfg_dx = DW'(dx);
        cfg_dy = DW'(dy);
        cfg_max_iter = IW'(mi);
    endtask

    initial begin
        int cyc;
        areset = 1'b1;
        enable = 1'b0;
        pix_ready = 1'b0;
        set_cfg(0, 0, 0, 0, 15);
        @(negedge aclk);
        tick(); tick(); tick();
        chk("rst_bus", {38'd0, pix_valid, frame_done, pix_sof, pix_eol, pix_escaped, pix_rgb, pix_iter},
            64'd0);
        areset = 1'b0;
        tick();

        // c = 0 never escapes
        set_cfg(0, 0, 0, 0, 15);
        run_frame(0, 1'b0);
        chk("c0_iter", 64'(first_iter), 64'd15);
        chk("c0_esc", {63'd0, first_esc}, 64'd0);
        chk("c0_rgb", 64'(first_rgb), 64'd0);
        chk("c0_latency", 64'(first_lat), 64'd18);

        // c = 2.0 reaches |z|^2 = 4 exactly, escapes one step later
        set_cfg(8192, 0, 0, 0, 15);
        run_frame(0, 1'b0);
        chk("c2_iter", 64'(first_iter), 64'd2);
        chk("c2_esc", {63'd0, first_esc}, 64'd1);
        chk("c2_rgb", 64'(first_rgb), 64'h040802);

        // limit of zero behaves as one
        set_cfg(0, 0, 0, 0, 0);
        run_frame(0, 1'b0);
        chk("lim0_iter", 64'(first_iter), 64'd1);

        set_cfg(int'($urandom_range(0, 10240)) - 8192, int'($urandom_range(0, 9830)) - 4915,
                int'($urandom_range(0, 1024)) - 512, int'($urandom_range(0, 1024)) - 512, 30);
        run_frame(2, 1'b0);

        for (int f = 0; f < 6; f++) begin
            set_cfg(int'($urandom_range(0, 10240)) - 8192, int'($urandom_range(0, 9830)) - 4915,
                    int'($urandom_range(0, 1024)) - 512, int'($urandom_range(0, 1024)) - 512,
                    int'($urandom_range(0, 40)));
            run_frame(1, f == 2);
        end

        set_cfg(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom_range(0, 40)));
        run_frame(1, 1'b1);

        repeat (30) tick();
        chk("no_start_without_enable", {63'd0, pix_valid}, 64'd0);

        // Reset during ITER of pixel (2,0)
        set_cfg(0, 0, 0, 0, 50);
        enable = 1'b1;
        wait_valid(cyc);
        enable = 1'b0;
        pix_ready = 1'b1; tick(); pix_ready = 1'b0;
        wait_valid(cyc);
        pix_ready = 1'b1; tick(); pix_ready = 1'b0;
        tick();
        tick();
        areset = 1'b1;
        tick();
        chk("rst_mid_valid", {63'd0, pix_valid}, 64'd0);
        chk("rst_mid_iter", 64'(pix_iter), 64'd0);
        areset = 1'b0;
        set_cfg(-6000, 1500, 700, -900, 25);
        run_frame(0, 1'b0);
        chk("rst_restart_sof_iter", 64'(first_iter), 64'(first_iter));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
